// File: rtl/cva6_ras_ckpt_pkg.sv
// Shared types and default configuration for the checkpointed return-address stack.
// The struct layouts follow the RAS_* fields, so a different configuration is made here.
package cva6_ras_ckpt_pkg;

    localparam int unsigned RAS_ADDR_W  = 64;
    localparam int unsigned RAS_DEPTH   = 4;
    localparam int unsigned RAS_NR_CKPT = 4;

    localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    // A single checkpoint slot still needs a 1-bit id port.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [RAS_PTR_W-1:0]  tos;
        logic [RAS_CNT_W-1:0]  count;
        logic [RAS_ADDR_W-1:0] top;
    } ras_ckpt_t;

    typedef struct packed {
        logic                  valid;
        logic [RAS_ADDR_W-1:0] ra;
    } ras_t;

endpackage

// File: rtl/cva6_ras_ckpt_if.sv
// Predecode/branch-unit side of the RAS: push/pop, checkpoint control and top-of-stack view.
interface cva6_ras_ckpt_if #(
    parameter int unsigned ADDR_W  = cva6_ras_ckpt_pkg::RAS_ADDR_W,
    parameter int unsigned NR_CKPT = cva6_ras_ckpt_pkg::RAS_NR_CKPT
);
    localparam int unsigned ID_W = cva6_ras_ckpt_pkg::id_width(NR_CKPT);

    logic              flush_i;
    logic              push_i;
    logic [ADDR_W-1:0] push_addr_i;
    logic              pop_i;
    logic              top_valid_o;
    logic [ADDR_W-1:0] top_addr_o;
    logic              ckpt_save_i;
    logic              ckpt_restore_i;
    logic [ID_W-1:0]   ckpt_id_i;
    logic              restore_err_o;

    modport master (
        output flush_i, push_i, push_addr_i, pop_i,
        output ckpt_save_i, ckpt_restore_i, ckpt_id_i,
        input  top_valid_o, top_addr_o, restore_err_o
    );

    modport slave (
        input  flush_i, push_i, push_addr_i, pop_i,
        input  ckpt_save_i, ckpt_restore_i, ckpt_id_i,
        output top_valid_o, top_addr_o, restore_err_o
    );

endinterface

// File: rtl/cva6_ras_ckpt.sv
// Circular return-address stack with overwrite-on-overflow and speculative checkpoints.
// Per-cycle priority: flush > restore > push/pop > save; all outputs come straight from flops.
module cva6_ras_ckpt
    import cva6_ras_ckpt_pkg::*;
#(
    parameter int unsigned ADDR_W  = RAS_ADDR_W,
    parameter int unsigned DEPTH   = RAS_DEPTH,
    parameter int unsigned NR_CKPT = RAS_NR_CKPT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    cva6_ras_ckpt_if.slave  ras
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][ADDR_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]             tos_q, tos_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    ras_ckpt_t [NR_CKPT-1:0]      ckpt_q, ckpt_d;
    logic [NR_CKPT-1:0]           ckpt_vld_q, ckpt_vld_d;
    ras_t                         top_q, top_d;
    logic                         err_q, err_d;
    ras_ckpt_t                    sel_ckpt;

    assign sel_ckpt = ckpt_q[ras.ckpt_id_i];

    always_comb begin
        mem_d      = mem_q;
        tos_d      = tos_q;
        cnt_d      = cnt_q;
        ckpt_d     = ckpt_q;
        ckpt_vld_d = ckpt_vld_q;
        err_d      = 1'b0;

        if (ras.flush_i) begin
            tos_d      = '0;
            cnt_d      = '0;
            ckpt_vld_d = '0;
        end else if (ras.ckpt_restore_i) begin
            // Rewrite the saved top too: the wrong path may have clobbered it.
            if (ckpt_vld_q[ras.ckpt_id_i]) begin
                tos_d                = sel_ckpt.tos;
                cnt_d                = sel_ckpt.count;
                mem_d[sel_ckpt.tos]  = sel_ckpt.top;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            if (ras.push_i && ras.pop_i) begin
                mem_d[tos_q] = ras.push_addr_i;
                if (cnt_q == '0) cnt_d = CNT_W'(1);
            end else if (ras.push_i) begin
                tos_d        = tos_q + PTR_W'(1);
                mem_d[tos_d] = ras.push_addr_i;
                if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
            end else if (ras.pop_i && cnt_q != '0) begin
                tos_d = tos_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end

            // Snapshot is the state before this cycle's push/pop.
            if (ras.ckpt_save_i) begin
                ckpt_d[ras.ckpt_id_i]     = '{tos: tos_q, count: cnt_q, top: mem_q[tos_q]};
                ckpt_vld_d[ras.ckpt_id_i] = 1'b1;
            end
        end

        top_d.valid = (cnt_d != '0);
        top_d.ra    = top_d.valid ? mem_d[tos_d] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q      <= '0;
            tos_q      <= '0;
            cnt_q      <= '0;
            ckpt_q     <= '0;
            ckpt_vld_q <= '0;
            top_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            tos_q      <= tos_d;
            cnt_q      <= cnt_d;
            ckpt_q     <= ckpt_d;
            ckpt_vld_q <= ckpt_vld_d;
            top_q      <= top_d;
            err_q      <= err_d;
        end
    end

    assign ras.top_valid_o   = top_q.valid;
    assign ras.top_addr_o    = top_q.ra;
    assign ras.restore_err_o = err_q;

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= CNT_W'(DEPTH));
    a_top_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ras.top_valid_o == (cnt_q != '0));
    a_no_x: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({ras.top_valid_o, ras.top_addr_o, ras.restore_err_o}));

endmodule

// File: tb/tb_cva6_ras_ckpt.sv
// Directed scoreboard bench for cva6_ras_ckpt (DEPTH=4, NR_CKPT=4).
module tb_cva6_ras_ckpt;

    typedef struct {
        logic        v;
        logic [63:0] a;
        logic        e;
        string       nm;
    } exp_t;

    localparam logic [4:0] IDLE = 5'b00000;
    localparam logic [4:0] FL   = 5'b10000;
    localparam logic [4:0] PU   = 5'b01000;
    localparam logic [4:0] PO   = 5'b00100;
    localparam logic [4:0] SV   = 5'b00010;
    localparam logic [4:0] RS   = 5'b00001;

    localparam logic [63:0] A = 64'h0000_0000_8000_0a00;
    localparam logic [63:0] B = 64'h0000_0000_8000_0b00;
    localparam logic [63:0] C = 64'h0000_0000_8000_0c00;
    localparam logic [63:0] D = 64'h0000_0000_8000_0d00;
    localparam logic [63:0] X = 64'h0000_0000_8000_0e00;
    localparam logic [63:0] Y = 64'h0000_0000_8000_1100;
    localparam logic [63:0] Z = 64'h0000_0000_8000_1200;
    localparam logic [63:0] Q = 64'h0000_0000_8000_1300;
    localparam logic [63:0] W = 64'h0000_0000_8000_1400;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    cva6_ras_ckpt_if #(.ADDR_W(64), .NR_CKPT(4)) ras ();

    cva6_ras_ckpt #(.ADDR_W(64), .DEPTH(4), .NR_CKPT(4)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ras    (ras)
    );

    function automatic void compare(input exp_t x);
        n_tests++;
        if (ras.top_valid_o !== x.v || ras.top_addr_o !== x.a || ras.restore_err_o !== x.e) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b addr=%h err=%0b, want valid=%0b addr=%h err=%0b",
                     x.nm, ras.top_valid_o, ras.top_addr_o, ras.restore_err_o, x.v, x.a, x.e);
        end
    endfunction

    // Monitor: the registered outputs of each accepted operation are checked mid-cycle.
    always @(negedge clk_i) begin
        if (sb.size() > 0) compare(sb.pop_front());
    end

    task automatic op(input logic [4:0] c, input logic [1:0] id, input logic [63:0] a,
                      input logic ev, input logic [63:0] ea, input logic ee, input string nm);
        exp_t x;
        ras.flush_i        = c[4];
        ras.push_i         = c[3];
        ras.pop_i          = c[2];
        ras.ckpt_save_i    = c[1];
        ras.ckpt_restore_i = c[0];
        ras.ckpt_id_i      = id;
        ras.push_addr_i    = a;
        @(posedge clk_i);
        #1;
        x.v = ev; x.a = ea; x.e = ee; x.nm = nm;
        sb.push_back(x);
        ras.flush_i        = 1'b0;
        ras.push_i         = 1'b0;
        ras.pop_i          = 1'b0;
        ras.ckpt_save_i    = 1'b0;
        ras.ckpt_restore_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk_i);
            #1;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations still pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_now(input string nm);
        exp_t x;
        x.v = 1'b0; x.a = '0; x.e = 1'b0; x.nm = nm;
        compare(x);
    endtask

    initial begin
        ras.flush_i = 1'b0; ras.push_i = 1'b0; ras.pop_i = 1'b0;
        ras.ckpt_save_i = 1'b0; ras.ckpt_restore_i = 1'b0;
        ras.ckpt_id_i = '0; ras.push_addr_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_now("reset_state");
        rst_ni = 1'b1;

        // basic push/pop and underflow
        op(PU, 0, A, 1, A, 0, "push_a");
        op(PU, 0, B, 1, B, 0, "push_b");
        op(PU, 0, C, 1, C, 0, "push_c");
        op(PO, 0, 0, 1, B, 0, "pop_to_b");
        op(PO, 0, 0, 1, A, 0, "pop_to_a");
        op(PO, 0, 0, 0, 0, 0, "pop_to_empty");
        op(PO, 0, 0, 0, 0, 0, "pop_on_empty");
        op(PU, 0, D, 1, D, 0, "push_after_underflow");
        op(PO, 0, 0, 0, 0, 0, "pop_count_was_0");

        // overflow overwrites the oldest
        for (int i = 1; i <= 6; i++) op(PU, 0, 64'(i), 1, 64'(i), 0, "ovf_push");
        op(PO, 0, 0, 1, 64'd5, 0, "ovf_pop_5");
        op(PO, 0, 0, 1, 64'd4, 0, "ovf_pop_4");
        op(PO, 0, 0, 1, 64'd3, 0, "ovf_pop_3");
        op(PO, 0, 0, 0, 0, 0, "ovf_pop_empty");
        op(PO, 0, 0, 0, 0, 0, "ovf_no_stale");

        // same-cycle push+pop
        op(PU, 0, A, 1, A, 0, "pp_push_a");
        op(PU, 0, B, 1, B, 0, "pp_push_b");
        op(PU | PO, 0, X, 1, X, 0, "pushpop_replace");
        op(PO, 0, 0, 1, A, 0, "pushpop_pop_a");
        op(PO, 0, 0, 0, 0, 0, "pushpop_pop_empty");
        op(PU | PO, 0, X, 1, X, 0, "pushpop_on_empty");
        op(PO, 0, 0, 0, 0, 0, "pushpop_count_1");

        // checkpoint and restore repairs the top
        op(PU, 0, A, 1, A, 0, "ck_push_a");
        op(PU, 0, B, 1, B, 0, "ck_push_b");
        op(SV, 2, 0, 1, B, 0, "ck_save2");
        op(PO, 0, 0, 1, A, 0, "ck_wrong_pop");
        op(PU, 0, Y, 1, Y, 0, "ck_wrong_push_y");
        op(PU, 0, Z, 1, Z, 0, "ck_wrong_push_z");
        op(RS, 2, 0, 1, B, 0, "ck_restore2");
        op(PO, 0, 0, 1, A, 0, "ck_pop_a");

        // invalid restore and restore-vs-push priority
        op(RS, 1, 0, 1, A, 1, "rs_invalid_err");
        op(IDLE, 0, 0, 1, A, 0, "rs_err_one_cycle");
        op(RS | PU, 1, X, 1, A, 1, "rs_invalid_push_dropped");
        op(PU, 0, B, 1, B, 0, "rs_push_b");
        op(RS | PU, 2, X, 1, B, 0, "rs_valid_push_dropped");
        op(SV | PU, 0, Q, 1, Q, 0, "save_with_push");
        op(RS, 0, 0, 1, B, 0, "restore_pre_push_state");

        // flush beats push and kills checkpoints
        op(FL | PU, 0, W, 0, 0, 0, "flush_with_push");
        op(RS, 2, 0, 0, 0, 1, "flush_invalidated_slot");
        op(IDLE, 0, 0, 0, 0, 0, "flush_idle");

        // asynchronous reset mid-sequence
        op(PU, 0, A, 1, A, 0, "pre_rst_push_a");
        op(PU, 0, B, 1, B, 0, "pre_rst_push_b");
        op(SV, 3, 0, 1, B, 0, "pre_rst_save3");
        drain();
        #2;
        rst_ni = 1'b0;
        #1;
        chk_now("async_reset_outputs");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        op(RS, 3, 0, 0, 0, 1, "reset_invalidated_slot");
        op(IDLE, 0, 0, 0, 0, 0, "post_reset_idle");

        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
